// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the set-associative cache controller: FSM state
// encoding and the line-offset width helper.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WB     = 3'd1,
        S_RD     = 3'd2,
        S_DONE   = 3'd3,
        S_CWRITE = 3'd4
    } state_t;

    // Number of bits needed to address a word within a line of 'words' words.
    function automatic int calc_offw(input int words);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < words) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/cache_assoc_controller_fill_tracker.sv
// Tracks in-flight memory reads: a MEM_LAT-deep pipe of issue flags whose
// output marks the cycle each word returns, plus the response word counter.
module fill_tracker
    import cache_ctrl_pkg::*;
#(
    parameter int WORDS   = 4,
    parameter int MEM_LAT = 2,
    parameter int OFFW    = calc_offw(WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue,
    output logic            fill_en,
    output logic [OFFW-1:0] fill_offset,
    output logic            last_fill
);

    logic [MEM_LAT-1:0] flag_pipe_reg;
    logic [OFFW-1:0]    rsp_cnt_reg;

    assign fill_en     = flag_pipe_reg[MEM_LAT-1];
    assign fill_offset = rsp_cnt_reg;
    assign last_fill   = fill_en && (rsp_cnt_reg == OFFW'(WORDS - 1));

    // Shift issue flags so each one surfaces exactly MEM_LAT cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_pipe_reg <= '0;
        end else begin
            flag_pipe_reg[0] <= issue;
            for (int i = 1; i < MEM_LAT; i++) begin
                flag_pipe_reg[i] <= flag_pipe_reg[i-1];
            end
        end
    end

    // Count returned words; the final word of the line returns it to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_cnt_reg <= '0;
        end else if (fill_en) begin
            rsp_cnt_reg <= last_fill ? '0 : rsp_cnt_reg + OFFW'(1);
        end
    end

endmodule

// File: rtl/cache_assoc_controller.sv
// Set-associative cache controller: zero-cycle hits, invalid-first then
// round-robin victim choice, dirty write-back and pipelined line refill.
module cache_assoc_controller
    import cache_ctrl_pkg::*;
#(
    parameter int WAYS    = 2,
    parameter int WORDS   = 4,
    parameter int MEM_LAT = 2,
    localparam int OFFW   = calc_offw(WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Rd,
    input  logic            Wr,
    input  logic [WAYS-1:0] hit,
    input  logic [WAYS-1:0] valid,
    input  logic [WAYS-1:0] dirty,
    input  logic            mem_stall,
    output logic            Stall,
    output logic            CacheHit,
    output logic            done,
    output logic            comp,
    output logic            write,
    output logic            valid_in,
    output logic [WAYS-1:0] way_sel,
    output logic            cache_in,
    output logic            mem_in,
    output logic            read_mem,
    output logic            write_mem,
    output logic [OFFW-1:0] mem_offset,
    output logic [OFFW-1:0] cache_offset
);

    state_t          state_reg;
    logic [OFFW-1:0] wb_cnt_reg;
    logic [OFFW:0]   req_cnt_reg;
    logic            rr_victim_reg;
    logic            victim_way_reg;

    logic            req;
    logic [WAYS-1:0] hit_valid;
    logic [WAYS:0]   hit_seen;
    logic [WAYS:0]   free_seen;
    logic [WAYS-1:0] hit_onehot;
    logic [WAYS-1:0] free_onehot;
    logic [WAYS-1:0] victim_sel;
    logic            any_hit;
    logic            any_free;
    logic            miss_victim;
    logic            victim_dirty;
    logic            issue;
    logic            fill_en;
    logic [OFFW-1:0] fill_offset;
    logic            last_fill;

    assign req       = Rd | Wr;
    assign hit_valid = hit & valid;

    // Priority chains: the lowest-indexed hitting way and lowest invalid way win.
    assign hit_seen[0]  = 1'b0;
    assign free_seen[0] = 1'b0;
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        assign hit_onehot[gi]   = hit_valid[gi] & ~hit_seen[gi];
        assign hit_seen[gi+1]   = hit_seen[gi] | hit_valid[gi];
        assign free_onehot[gi]  = ~valid[gi] & ~free_seen[gi];
        assign free_seen[gi+1]  = free_seen[gi] | ~valid[gi];
        assign victim_sel[gi]   = (1'(gi) == victim_way_reg);
    end

    assign any_hit  = hit_seen[WAYS];
    assign any_free = free_seen[WAYS];

    // Choose the miss victim and find out whether it must be written back.
    always_comb begin
        miss_victim  = rr_victim_reg;
        victim_dirty = 1'b0;
        if (any_free) begin
            for (int i = 0; i < WAYS; i++) begin
                if (free_onehot[i]) begin
                    miss_victim = 1'(i);
                end
            end
        end
        for (int i = 0; i < WAYS; i++) begin
            if (1'(i) == miss_victim) begin
                victim_dirty = valid[i] & dirty[i];
            end
        end
    end

    // A read goes out whenever words remain to request and memory is ready.
    assign issue = (state_reg == S_RD) && !req_cnt_reg[OFFW] && !mem_stall;

    fill_tracker #(
        .WORDS   (WORDS),
        .MEM_LAT (MEM_LAT),
        .OFFW    (OFFW)
    ) u_fill_tracker (
        .clk         (clk),
        .rst         (rst),
        .issue       (issue),
        .fill_en     (fill_en),
        .fill_offset (fill_offset),
        .last_fill   (last_fill)
    );

    // Controller state, counters and victim bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            wb_cnt_reg     <= '0;
            req_cnt_reg    <= '0;
            rr_victim_reg  <= 1'b0;
            victim_way_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req) begin
                        if (WAYS == 2) begin
                            rr_victim_reg <= ~rr_victim_reg;
                        end
                        if (!any_hit) begin
                            victim_way_reg <= miss_victim;
                            state_reg      <= victim_dirty ? S_WB : S_RD;
                        end
                    end
                end
                S_WB: begin
                    if (!mem_stall) begin
                        if (wb_cnt_reg == OFFW'(WORDS - 1)) begin
                            wb_cnt_reg <= '0;
                            state_reg  <= S_RD;
                        end else begin
                            wb_cnt_reg <= wb_cnt_reg + OFFW'(1);
                        end
                    end
                end
                S_RD: begin
                    if (issue) begin
                        req_cnt_reg <= req_cnt_reg + (OFFW+1)'(1);
                    end
                    if (last_fill) begin
                        req_cnt_reg <= '0;
                        state_reg   <= Wr ? S_CWRITE : S_DONE;
                    end
                end
                S_DONE, S_CWRITE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Decode cache-array and memory controls from the current state.
    always_comb begin
        Stall        = (state_reg != S_IDLE);
        CacheHit     = 1'b0;
        done         = 1'b0;
        comp         = 1'b0;
        write        = 1'b0;
        valid_in     = 1'b0;
        way_sel      = '0;
        cache_in     = 1'b0;
        mem_in       = 1'b0;
        read_mem     = 1'b0;
        write_mem    = 1'b0;
        mem_offset   = '0;
        cache_offset = '0;
        case (state_reg)
            S_IDLE: begin
                comp = req;
                if (req && any_hit) begin
                    CacheHit = 1'b1;
                    done     = 1'b1;
                    way_sel  = hit_onehot;
                    write    = Wr;
                end
            end
            S_WB: begin
                write_mem    = 1'b1;
                mem_in       = 1'b1;
                way_sel      = victim_sel;
                mem_offset   = wb_cnt_reg;
                cache_offset = wb_cnt_reg;
            end
            S_RD: begin
                read_mem   = !req_cnt_reg[OFFW];
                mem_offset = req_cnt_reg[OFFW-1:0];
                if (fill_en) begin
                    write        = 1'b1;
                    valid_in     = 1'b1;
                    cache_in     = 1'b1;
                    way_sel      = victim_sel;
                    cache_offset = fill_offset;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            S_CWRITE: begin
                comp     = 1'b1;
                write    = 1'b1;
                valid_in = 1'b1;
                way_sel  = victim_sel;
                done     = 1'b1;
            end
            default: begin
                Stall = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_assoc_controller.sv
// Bench for cache_assoc_controller: directed scenarios plus randomized
// requests checked cycle by cycle against a transaction-level schedule model.
module tb_cache_assoc_controller;

    localparam int WAYS    = 2;
    localparam int WORDS   = 4;
    localparam int MEM_LAT = 2;
    localparam int MAXC    = 96;

    typedef struct packed {
        logic       stall;
        logic       chit;
        logic       done;
        logic       comp;
        logic       write;
        logic       valid_in;
        logic [1:0] way_sel;
        logic       cache_in;
        logic       mem_in;
        logic       read_mem;
        logic       write_mem;
        logic [1:0] mem_offset;
        logic [1:0] cache_offset;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Main instance (2 ways, 4 words, latency 2)
    logic       Rd = 1'b0, Wr = 1'b0, mem_stall = 1'b0;
    logic [1:0] hit = '0, valid = '0, dirty = '0;
    logic       Stall, CacheHit, done, comp, write, valid_in, cache_in, mem_in, read_mem, write_mem;
    logic [1:0] way_sel, mem_offset, cache_offset;

    // Small instance (1 way, 8 words, latency 3)
    logic       s_Rd = 1'b0, s_Wr = 1'b0, s_mem_stall = 1'b0;
    logic [0:0] s_hit = '0, s_valid = '0, s_dirty = '0;
    logic       s_Stall, s_CacheHit, s_done, s_comp, s_write, s_valid_in, s_cache_in, s_mem_in;
    logic       s_read_mem, s_write_mem;
    logic [0:0] s_way_sel;
    logic [2:0] s_mem_offset, s_cache_offset;

    out_t obs;
    out_t exp_q [MAXC];
    bit   stall_pat [MAXC];
    int   vr_model = 0;
    int   passed = 0;
    int   total = 0;

    assign obs = {Stall, CacheHit, done, comp, write, valid_in, way_sel, cache_in, mem_in,
                  read_mem, write_mem, mem_offset, cache_offset};

    always #5 clk = ~clk;

    cache_assoc_controller #(.WAYS(2), .WORDS(4), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .hit(hit), .valid(valid), .dirty(dirty),
        .mem_stall(mem_stall), .Stall(Stall), .CacheHit(CacheHit), .done(done), .comp(comp),
        .write(write), .valid_in(valid_in), .way_sel(way_sel), .cache_in(cache_in),
        .mem_in(mem_in), .read_mem(read_mem), .write_mem(write_mem),
        .mem_offset(mem_offset), .cache_offset(cache_offset)
    );

    cache_assoc_controller #(.WAYS(1), .WORDS(8), .MEM_LAT(3)) dut_small (
        .clk(clk), .rst(rst), .Rd(s_Rd), .Wr(s_Wr), .hit(s_hit), .valid(s_valid), .dirty(s_dirty),
        .mem_stall(s_mem_stall), .Stall(s_Stall), .CacheHit(s_CacheHit), .done(s_done),
        .comp(s_comp), .write(s_write), .valid_in(s_valid_in), .way_sel(s_way_sel),
        .cache_in(s_cache_in), .mem_in(s_mem_in), .read_mem(s_read_mem),
        .write_mem(s_write_mem), .mem_offset(s_mem_offset), .cache_offset(s_cache_offset)
    );

    task automatic clear_stalls;
        for (int i = 0; i < MAXC; i++) stall_pat[i] = 1'b0;
    endtask

    // Expected per-cycle outputs of one request, derived from the request,
    // the way status and the memory-stall pattern; cycle 0 is the request cycle.
    task automatic build_expected(input logic rd, input logic wr, input logic [1:0] h,
                                  input logic [1:0] v, input logic [1:0] d, output int last);
        logic [1:0] hv, oh;
        int         vict, c, issued, k;
        int         fill_at [WORDS];
        bit         finished;
        for (int i = 0; i < MAXC; i++) exp_q[i] = '0;
        for (int j = 0; j < WORDS; j++) fill_at[j] = -1;
        hv = h & v;
        exp_q[0].comp = rd | wr;
        vr_model = 1 - vr_model;
        if (hv != 2'b00) begin
            exp_q[0].chit    = 1'b1;
            exp_q[0].done    = 1'b1;
            exp_q[0].write   = wr;
            exp_q[0].way_sel = hv[0] ? 2'b01 : 2'b10;
            last = 0;
        end else begin
            vict = !v[0] ? 0 : (!v[1] ? 1 : 1 - vr_model);
            oh = (vict == 0) ? 2'b01 : 2'b10;
            c = 1;
            if (v[vict] && d[vict]) begin
                k = 0;
                while (k < WORDS) begin
                    exp_q[c].stall        = 1'b1;
                    exp_q[c].write_mem    = 1'b1;
                    exp_q[c].mem_in       = 1'b1;
                    exp_q[c].way_sel      = oh;
                    exp_q[c].mem_offset   = 2'(k);
                    exp_q[c].cache_offset = 2'(k);
                    if (!stall_pat[c]) k++;
                    c++;
                end
            end
            issued = 0;
            finished = 1'b0;
            while (!finished) begin
                exp_q[c].stall      = 1'b1;
                exp_q[c].mem_offset = 2'(issued % WORDS);
                if (issued < WORDS) begin
                    exp_q[c].read_mem = 1'b1;
                    if (!stall_pat[c]) begin
                        fill_at[issued] = c + MEM_LAT;
                        issued++;
                    end
                end
                for (int j = 0; j < WORDS; j++) begin
                    if (fill_at[j] == c) begin
                        exp_q[c].write        = 1'b1;
                        exp_q[c].valid_in     = 1'b1;
                        exp_q[c].cache_in     = 1'b1;
                        exp_q[c].way_sel      = oh;
                        exp_q[c].cache_offset = 2'(j);
                        if (j == WORDS - 1) finished = 1'b1;
                    end
                end
                c++;
            end
            exp_q[c].stall = 1'b1;
            exp_q[c].done  = 1'b1;
            if (wr) begin
                exp_q[c].comp     = 1'b1;
                exp_q[c].write    = 1'b1;
                exp_q[c].valid_in = 1'b1;
                exp_q[c].way_sel  = oh;
            end
            last = c;
        end
    endtask

    // Drive one request (entered at posedge+1) and compare every cycle through
    // the first idle cycle after completion.
    task automatic run_txn(input string name, input logic rd, input logic wr,
                           input logic [1:0] h, input logic [1:0] v, input logic [1:0] d);
        int last;
        int bad;
        build_expected(rd, wr, h, v, d, last);
        bad = 0;
        hit = h; valid = v; dirty = d;
        for (int c = 0; c <= last + 1; c++) begin
            Rd = (c <= last) ? rd : 1'b0;
            Wr = (c <= last) ? wr : 1'b0;
            mem_stall = stall_pat[c];
            @(negedge clk);
            total++;
            if (obs !== exp_q[c]) begin
                $display("FAIL %s cycle %0d outputs got %h expected %h", name, c,
                         16'(obs), 16'(exp_q[c]));
                bad++;
            end else begin
                passed++;
            end
            @(posedge clk); #1;
        end
        mem_stall = 1'b0;
        $display("txn %s rd=%0d wr=%0d hit=%b valid=%b dirty=%b done_cycle=%0d errors=%0d",
                 name, rd, wr, h, v, d, last, bad);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (obs !== out_t'(0) || {s_Stall, s_done, s_comp, s_write, s_way_sel, s_read_mem,
                                      s_write_mem, s_mem_offset, s_cache_offset} !== 14'd0) begin
                $display("FAIL reset_idle cycle %0d outputs got %h small %b expected all zero", c,
                         16'(obs), {s_Stall, s_done, s_comp, s_write, s_way_sel});
            end else begin
                passed++;
            end
            @(posedge clk); #1;
        end
        vr_model = 0;
        $display("txn reset checked idle outputs");
    endtask

    task automatic test_read_hit;
        clear_stalls();
        run_txn("read_hit_way1", 1'b1, 1'b0, 2'b10, 2'b11, 2'b00);
        run_txn("write_hit_both_low_wins", 1'b0, 1'b1, 2'b11, 2'b11, 2'b11);
    endtask

    task automatic test_clean_miss;
        clear_stalls();
        run_txn("clean_read_miss", 1'b1, 1'b0, 2'b00, 2'b10, 2'b10);
    endtask

    task automatic test_dirty_write_miss;
        clear_stalls();
        if (vr_model == 0) run_txn("align_victim_hit", 1'b1, 1'b0, 2'b01, 2'b01, 2'b00);
        run_txn("dirty_write_miss_way1", 1'b0, 1'b1, 2'b00, 2'b11, 2'b10);
        run_txn("full_clean_miss_way0", 1'b1, 1'b0, 2'b00, 2'b11, 2'b00);
    endtask

    task automatic test_mem_stall;
        clear_stalls();
        stall_pat[2] = 1'b1;
        stall_pat[3] = 1'b1;
        run_txn("stalled_read_miss", 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
        clear_stalls();
        stall_pat[2] = 1'b1;
        stall_pat[6] = 1'b1;
        run_txn("stalled_dirty_rdwr_miss", 1'b1, 1'b1, 2'b00, 2'b01, 2'b01);
        clear_stalls();
    endtask

    task automatic test_reset_mid;
        int last;
        clear_stalls();
        build_expected(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, last);
        hit = 2'b00; valid = 2'b00; dirty = 2'b00;
        for (int c = 0; c <= 4; c++) begin
            Rd = 1'b1; Wr = 1'b0;
            if (c == 4) rst = 1'b1;
            @(negedge clk);
            total++;
            if (obs !== exp_q[c]) begin
                $display("FAIL reset_mid_pre cycle %0d outputs got %h expected %h", c,
                         16'(obs), 16'(exp_q[c]));
            end else begin
                passed++;
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        Rd = 1'b0;
        vr_model = 0;
        for (int c = 5; c <= 10; c++) begin
            @(negedge clk);
            total++;
            if (obs !== out_t'(0)) begin
                $display("FAIL reset_mid_post cycle %0d outputs got %h expected 0000", c, 16'(obs));
            end else begin
                passed++;
            end
            @(posedge clk); #1;
        end
        $display("txn reset_mid rst at second fill, idle afterwards");
    endtask

    task automatic test_random;
        logic       rd, wr;
        int         sel;
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 2);
            rd = (sel != 1);
            wr = (sel != 0);
            for (int i = 0; i < MAXC; i++)
                stall_pat[i] = (i >= 1 && i <= 40) ? ($urandom_range(0, 3) == 0) : 1'b0;
            run_txn($sformatf("random_%0d", n), rd, wr, 2'($urandom), 2'($urandom), 2'($urandom));
        end
        clear_stalls();
    endtask

    // One-way, eight-word, latency-3 build: clean miss then a hit.
    task automatic test_small_cfg;
        logic [13:0] got, want;
        logic        e_fill;
        s_valid = 1'b0; s_hit = 1'b0; s_dirty = 1'b0;
        for (int c = 0; c <= 13; c++) begin
            s_Rd = (c <= 12);
            @(negedge clk);
            e_fill = (c >= 4 && c <= 11);
            want = {(c >= 1 && c <= 12), 1'b0, (c == 12), (c == 0), e_fill, e_fill, e_fill,
                    (c >= 1 && c <= 8), 1'b0,
                    (c >= 1 && c <= 8) ? 3'(c - 1) : 3'd0, e_fill ? 3'(c - 4) : 3'd0};
            got  = {s_Stall, s_CacheHit, s_done, s_comp, s_write, s_valid_in, s_way_sel,
                    s_read_mem, s_write_mem, s_mem_offset, s_cache_offset};
            total++;
            if (got !== want) begin
                $display("FAIL small_miss cycle %0d outputs got %b expected %b", c, got, want);
            end else begin
                passed++;
            end
            @(posedge clk); #1;
        end
        s_hit = 1'b1; s_valid = 1'b1; s_Rd = 1'b1;
        @(negedge clk);
        got  = {s_Stall, s_CacheHit, s_done, s_comp, s_write, s_valid_in, s_way_sel,
                s_read_mem, s_write_mem, s_mem_offset, s_cache_offset};
        want = 14'b0_1_1_1_0_0_1_0_0_000_000;
        total++;
        if (got !== want) begin
            $display("FAIL small_hit outputs got %b expected %b", got, want);
        end else begin
            passed++;
        end
        @(posedge clk); #1;
        s_Rd = 1'b0; s_hit = 1'b0; s_valid = 1'b0;
        $display("txn small_cfg clean miss done at cycle 12 and hit");
    endtask

    initial begin
        clear_stalls();
        test_reset();
        test_read_hit();
        test_clean_miss();
        test_dirty_write_miss();
        test_mem_stall();
        test_reset_mid();
        test_random();
        test_small_cfg();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
